// File: rtl/gpio_input_conditioner_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : gpio_input_conditioner_if
// Description : Bundle of GPIO pin, enable/clear controls and conditioned
//               outputs exchanged between the MMIO register block (master)
//               and the input conditioner (slave).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface gpio_input_conditioner_if #(
  parameter int GPIO_WIDTH = 8
);
  logic [GPIO_WIDTH-1:0] i_gpio_async;
  logic [GPIO_WIDTH-1:0] i_rise_en;
  logic [GPIO_WIDTH-1:0] i_fall_en;
  logic [GPIO_WIDTH-1:0] i_irq_en;
  logic [GPIO_WIDTH-1:0] i_clear;
  logic [GPIO_WIDTH-1:0] o_gpio_in;
  logic [GPIO_WIDTH-1:0] o_rise;
  logic [GPIO_WIDTH-1:0] o_fall;
  logic [GPIO_WIDTH-1:0] o_event;
  logic                  o_irq;

  modport master (
    output i_gpio_async, i_rise_en, i_fall_en, i_irq_en, i_clear,
    input  o_gpio_in, o_rise, o_fall, o_event, o_irq
  );

  modport slave (
    input  i_gpio_async, i_rise_en, i_fall_en, i_irq_en, i_clear,
    output o_gpio_in, o_rise, o_fall, o_event, o_irq
  );
endinterface
`default_nettype wire

// File: rtl/gpio_input_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : gpio_input_conditioner
// Description : Per-bit synchronizer, debounce filter and edge detector for
//               asynchronous GPIO pins, with sticky write-1-to-clear edge
//               flags and a masked level interrupt.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module gpio_input_conditioner #(
  parameter int GPIO_WIDTH      = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  gpio_input_conditioner_if.slave   bus
);

  localparam int                   CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q;
  logic [GPIO_WIDTH-1:0] smp_w;
  logic [GPIO_WIDTH-1:0] stb_d,   stb_q;
  logic [GPIO_WIDTH-1:0] stb_prev_q;
  logic [GPIO_WIDTH-1:0] rise_d,  rise_q;
  logic [GPIO_WIDTH-1:0] fall_d,  fall_q;
  logic [GPIO_WIDTH-1:0] event_d, event_q;

  // Shift the raw pins through the synchronizer chain; stage 0 takes the pins.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_gpio_async};
    end
  end

  assign smp_w = sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_bit
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic                 flip_w;

    // Count consecutive disagreeing samples; the last one flips the level.
    always_comb begin
      cnt_d  = '0;
      flip_w = 1'b0;
      if (smp_w[g] != stb_q[g]) begin
        if (cnt_q == CNT_LAST) begin
          flip_w = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    end

    // Hold the per-bit debounce count.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stb_d[g] = flip_w ? smp_w[g] : stb_q[g];
  end

  // Edges are detected against the previous stable level, so pulses trail the
  // level change by one cycle. A set in the same cycle as a clear wins.
  assign rise_d  = stb_q & ~stb_prev_q;
  assign fall_d  = ~stb_q & stb_prev_q;
  assign event_d = (event_q & ~bus.i_clear)
                 | (rise_q & bus.i_rise_en)
                 | (fall_q & bus.i_fall_en);

  // Register stable level, edge pulses and sticky event flags.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stb_q      <= '0;
      stb_prev_q <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      event_q    <= '0;
    end else begin
      stb_q      <= stb_d;
      stb_prev_q <= stb_q;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      event_q    <= event_d;
    end
  end

  assign bus.o_gpio_in = stb_q;
  assign bus.o_rise    = rise_q;
  assign bus.o_fall    = fall_q;
  assign bus.o_event   = event_q;
  assign bus.o_irq     = |(event_q & bus.i_irq_en);

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_gpio_input_conditioner
// Description : Scoreboard bench for gpio_input_conditioner. Instance A uses
//               default parameters, instance B uses SYNC_STAGES=3 and
//               DEBOUNCE_CYCLES=1. Expected values are queued with the edge
//               count at which they must be visible and compared at negedge.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_gpio_input_conditioner;

  localparam int SEL_GPIO  = 0;
  localparam int SEL_RISE  = 1;
  localparam int SEL_FALL  = 2;
  localparam int SEL_EVENT = 3;
  localparam int SEL_IRQ   = 4;
  localparam int SEL_B     = 5;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] val;
    string       tag;
  } sb_entry_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   edge_n  = 0;
  int   n_total = 0;
  int   n_pass  = 0;
  sb_entry_t sb[$];

  gpio_input_conditioner_if #(.GPIO_WIDTH(8)) ifa ();
  gpio_input_conditioner_if #(.GPIO_WIDTH(8)) ifb ();

  gpio_input_conditioner #(
    .GPIO_WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)
  ) dut_a (
    .i_clk(clk), .i_rstn(rstn), .bus(ifa)
  );

  gpio_input_conditioner #(
    .GPIO_WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)
  ) dut_b (
    .i_clk(clk), .i_rstn(rstn), .bus(ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
  endtask

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      SEL_GPIO:          return {24'd0, ifa.o_gpio_in};
      SEL_RISE:          return {24'd0, ifa.o_rise};
      SEL_FALL:          return {24'd0, ifa.o_fall};
      SEL_EVENT:         return {24'd0, ifa.o_event};
      SEL_IRQ:           return {31'd0, ifa.o_irq};
      SEL_B + SEL_GPIO:  return {24'd0, ifb.o_gpio_in};
      SEL_B + SEL_RISE:  return {24'd0, ifb.o_rise};
      SEL_B + SEL_FALL:  return {24'd0, ifb.o_fall};
      SEL_B + SEL_EVENT: return {24'd0, ifb.o_event};
      SEL_B + SEL_IRQ:   return {31'd0, ifb.o_irq};
      default:           return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Queue an expectation that must hold at the negedge dly edges from now.
  task automatic exp_at(input int dly, input int sel, input logic [31:0] v, input string tag);
    sb_entry_t e;
    e.due = edge_n + dly;
    e.sel = sel;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Pop and compare every expectation that has come due.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= edge_n) begin
        chk(sb[i].tag, sample(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    ifa.i_gpio_async = 8'hFF; ifa.i_rise_en = 8'hFF; ifa.i_fall_en = 8'h00;
    ifa.i_irq_en     = 8'hFF; ifa.i_clear   = 8'h00;
    ifb.i_gpio_async = 8'h00; ifb.i_rise_en = 8'h01; ifb.i_fall_en = 8'h01;
    ifb.i_irq_en     = 8'h01; ifb.i_clear   = 8'h00;
    step(3);

    // Reset state with pins high
    chk("rst_gpio",  {24'd0, ifa.o_gpio_in}, 32'h0);
    chk("rst_rise",  {24'd0, ifa.o_rise},    32'h0);
    chk("rst_fall",  {24'd0, ifa.o_fall},    32'h0);
    chk("rst_event", {24'd0, ifa.o_event},   32'h0);
    chk("rst_irq",   {31'd0, ifa.o_irq},     32'h0);
    chk("rst_b_evt", {24'd0, ifb.o_event},   32'h0);

    rstn = 1'b1;
    exp_at(17, SEL_GPIO,  32'h00, "rel_gpio_early");
    exp_at(18, SEL_GPIO,  32'hFF, "rel_gpio");
    exp_at(18, SEL_RISE,  32'h00, "rel_rise_early");
    exp_at(19, SEL_RISE,  32'hFF, "rel_rise");
    exp_at(20, SEL_RISE,  32'h00, "rel_rise_1cyc");
    exp_at(19, SEL_EVENT, 32'h00, "rel_event_early");
    exp_at(20, SEL_EVENT, 32'hFF, "rel_event");
    exp_at(20, SEL_IRQ,   32'h1,  "rel_irq");
    step(22);

    ifa.i_clear = 8'hFF;
    exp_at(1, SEL_EVENT, 32'h00, "clr_all_event");
    exp_at(1, SEL_IRQ,   32'h0,  "clr_all_irq");
    step(1);
    ifa.i_clear = 8'h00;

    // All pins low, falls not enabled
    ifa.i_rise_en = 8'h00;
    ifa.i_gpio_async = 8'h00;
    exp_at(18, SEL_GPIO,  32'h00, "low_gpio");
    exp_at(19, SEL_FALL,  32'hFF, "low_fall");
    exp_at(21, SEL_EVENT, 32'h00, "low_event_masked");
    step(22);

    // Glitch rejection: 15 cycles rejected, 16 accepted
    ifa.i_rise_en = 8'hFF;
    ifa.i_gpio_async = 8'h08;
    exp_at(18, SEL_GPIO,  32'h00, "g15_gpio");
    exp_at(20, SEL_GPIO,  32'h00, "g15_gpio_late");
    exp_at(19, SEL_RISE,  32'h00, "g15_rise");
    exp_at(22, SEL_EVENT, 32'h00, "g15_event");
    step(15);
    ifa.i_gpio_async = 8'h00;
    step(15);

    ifa.i_gpio_async = 8'h08;
    exp_at(17, SEL_GPIO,  32'h00, "g16_gpio_early");
    exp_at(18, SEL_GPIO,  32'h08, "g16_gpio");
    exp_at(19, SEL_RISE,  32'h08, "g16_rise");
    exp_at(20, SEL_EVENT, 32'h08, "g16_event");
    exp_at(34, SEL_GPIO,  32'h00, "g16_gpio_back");
    exp_at(35, SEL_FALL,  32'h08, "g16_fall");
    step(16);
    ifa.i_gpio_async = 8'h00;
    step(25);

    // Edge masking and interrupt
    ifa.i_rise_en = 8'h00; ifa.i_fall_en = 8'h01; ifa.i_irq_en = 8'h01;
    ifa.i_clear = 8'hFF;
    exp_at(1, SEL_EVENT, 32'h00, "mask_clr");
    step(1);
    ifa.i_clear = 8'h00;
    ifa.i_gpio_async = 8'h03;
    exp_at(18, SEL_GPIO,  32'h03, "mask_gpio_hi");
    exp_at(20, SEL_EVENT, 32'h00, "mask_rise_ignored");
    step(25);
    ifa.i_gpio_async = 8'h00;
    exp_at(18, SEL_GPIO,  32'h00, "mask_gpio_lo");
    exp_at(19, SEL_FALL,  32'h03, "mask_fall");
    exp_at(19, SEL_EVENT, 32'h00, "mask_event_early");
    exp_at(20, SEL_EVENT, 32'h01, "mask_event");
    exp_at(20, SEL_IRQ,   32'h1,  "mask_irq");
    step(25);
    ifa.i_irq_en = 8'h00;
    #1;
    chk("irq_drop",    {31'd0, ifa.o_irq},   32'h0);
    chk("irq_ev_hold", {24'd0, ifa.o_event}, 32'h01);
    exp_at(1, SEL_EVENT, 32'h01, "irq_ev_hold_next");
    step(1);

    // Clear and collision
    ifa.i_fall_en = 8'h03;
    ifa.i_gpio_async = 8'h03;
    step(25);
    ifa.i_gpio_async = 8'h00;
    exp_at(20, SEL_EVENT, 32'h03, "cc_event_03");
    step(25);
    ifa.i_clear = 8'h01;
    exp_at(1, SEL_EVENT, 32'h02, "cc_clear_bit0");
    step(1);
    ifa.i_clear = 8'h00;
    ifa.i_rise_en = 8'h02;
    ifa.i_gpio_async = 8'h02;
    exp_at(19, SEL_RISE,  32'h02, "cc_rise");
    exp_at(20, SEL_EVENT, 32'h02, "cc_collide");
    exp_at(21, SEL_EVENT, 32'h02, "cc_collide_hold");
    step(19);
    ifa.i_clear = 8'h02;
    step(1);
    ifa.i_clear = 8'h00;
    step(10);

    // Reset mid-debounce on bit 5
    ifa.i_gpio_async = 8'h22;
    step(10);
    rstn = 1'b0;
    #1;
    chk("mid_rst_event", {24'd0, ifa.o_event},   32'h0);
    chk("mid_rst_gpio",  {24'd0, ifa.o_gpio_in}, 32'h0);
    step(2);
    rstn = 1'b1;
    exp_at(17, SEL_GPIO, 32'h00, "mid_gpio_early");
    exp_at(18, SEL_GPIO, 32'h22, "mid_gpio");
    step(22);

    // Parameter corner: single-sample glitch accepted by instance B
    ifb.i_gpio_async = 8'h01;
    exp_at(3, SEL_B + SEL_GPIO,  32'h00, "b_gpio_early");
    exp_at(4, SEL_B + SEL_GPIO,  32'h01, "b_gpio");
    exp_at(5, SEL_B + SEL_GPIO,  32'h00, "b_gpio_back");
    exp_at(5, SEL_B + SEL_RISE,  32'h01, "b_rise");
    exp_at(6, SEL_B + SEL_FALL,  32'h01, "b_fall");
    exp_at(6, SEL_B + SEL_EVENT, 32'h01, "b_event");
    exp_at(6, SEL_B + SEL_IRQ,   32'h1,  "b_irq");
    step(1);
    ifb.i_gpio_async = 8'h00;
    step(10);

    chk("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
